// File: rtl/pwm_cmd_pkg.sv
// Shared widths, command record and receiver state encoding for pwm_cmd_scheduler.
package pwm_cmd_pkg;

  localparam int ADDR_W  = 3;
  localparam int VAL_W   = 3;
  localparam int FRAME_W = ADDR_W + VAL_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [VAL_W-1:0]  val;
  } pwm_cmd_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_DONE
  } rx_state_t;

endpackage

// File: rtl/pwm_cmd_scheduler_if.sv
// Write port toward the PWM driver: single-cycle set strobe with channel address and level.
interface pwm_cmd_scheduler_if;
  import pwm_cmd_pkg::*;

  logic              set;
  logic [ADDR_W-1:0] addr;
  logic [VAL_W-1:0]  val;

  modport master (output set, output addr, output val);
  modport slave  (input  set, input  addr, input  val);

endinterface

// File: rtl/pwm_cmd_fifo.sv
// Synchronous FIFO of pwm_cmd_t; pointers carry one extra wrap bit to tell full from empty.
module pwm_cmd_fifo
  import pwm_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  pwm_cmd_t push_data,
  input  logic     pop,
  output pwm_cmd_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  pwm_cmd_t    mem [DEPTH];
  logic        do_pop;
  logic        do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is left unreset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pwm_cmd_scheduler.sv
// Serial command receiver, command FIFO and write issue for the 8-channel PWM driver.
// Define PWM_CMD_SYNC_APPLY_EN to release at most one write per period, on period_end.
module pwm_cmd_scheduler
  import pwm_cmd_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_cs_n,
  input  logic                s_sclk,
  input  logic                s_sdi,
  input  logic                period_end,
  pwm_cmd_scheduler_if.master wr,
  output logic                busy,
  output logic                overflow,
  output logic                frame_err
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   cs_prev;
  logic                   sclk_prev;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sclk_rise;
  logic                   sdi_s;

  // Synchronizers clear to 0 so a frame already low at reset release never looks like a new start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      sdi_sync  <= '0;
      cs_prev   <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= SYNC_STAGES'({cs_sync, s_cs_n});
      sclk_sync <= SYNC_STAGES'({sclk_sync, s_sclk});
      sdi_sync  <= SYNC_STAGES'({sdi_sync, s_sdi});
      cs_prev   <= cs_sync[SYNC_STAGES-1];
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_prev;
  assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_prev;
  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];

  rx_state_t          state;
  logic [FRAME_W-1:0] shreg;
  logic [2:0]         bit_cnt;
  logic               push_req;
  pwm_cmd_t           push_cmd;
  logic               frame_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RX_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      push_req    <= 1'b0;
      push_cmd    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      push_req    <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          if (cs_fall) begin
            state   <= RX_SHIFT;
            shreg   <= '0;
            bit_cnt <= '0;
          end
        end
        RX_SHIFT: begin
          // Frame end wins over a coincident clock edge.
          if (cs_rise) begin
            state <= RX_DONE;
          end else if (sclk_rise) begin
            shreg <= {shreg[FRAME_W-2:0], sdi_s};
            if (bit_cnt != 3'd7) bit_cnt <= bit_cnt + 3'd1;
          end
        end
        RX_DONE: begin
          state <= RX_IDLE;
          if (bit_cnt == 3'(FRAME_W)) begin
            push_req <= 1'b1;
            push_cmd <= pwm_cmd_t'(shreg);
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  logic     fifo_full;
  logic     fifo_empty;
  pwm_cmd_t fifo_head;
  logic     pop;
  logic     set_q;
  logic     overflow_q;
  pwm_cmd_t issued;

`ifdef PWM_CMD_SYNC_APPLY_EN
  assign pop = ~fifo_empty & period_end & ~set_q;
`else
  logic unused_period_end;
  assign unused_period_end = period_end;
  assign pop = ~fifo_empty & ~set_q;
`endif

  pwm_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      set_q      <= 1'b0;
      issued     <= '0;
      overflow_q <= 1'b0;
    end else begin
      set_q      <= pop;
      overflow_q <= push_req & fifo_full & ~pop;
      if (pop) issued <= fifo_head;
    end
  end

  assign wr.set    = set_q;
  assign wr.addr   = issued.addr;
  assign wr.val    = issued.val;
  assign busy      = ~fifo_empty;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
